// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: owns the reg_file write port and arbitrates write-back between
// the ALU pipeline and the multi-cycle MDU. Keeps a 32-entry scoreboard of
// registers that still have an MDU result pending and drives the decode stall.
// Optional feature: define RWA_STARVE_EN to force an ALU grant after MAX_WAIT
// consecutive denied cycles; without it the MDU has strict priority.
module reg_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic            ip_clk,
  input  logic            ip_rst,
  input  logic            ip_alu_valid,
  input  logic [4:0]      ip_alu_rd_addr,
  input  logic [XLEN-1:0] ip_alu_data,
  output logic            op_alu_ready,
  input  logic            ip_mdu_valid,
  input  logic [4:0]      ip_mdu_rd_addr,
  input  logic [XLEN-1:0] ip_mdu_data,
  output logic            op_mdu_ready,
  input  logic            ip_mdu_issue,
  input  logic [4:0]      ip_mdu_issue_rd,
  input  logic [4:0]      ip_rs1_addr,
  input  logic [4:0]      ip_rs2_addr,
  input  logic [4:0]      ip_dec_rd_addr,
  output logic            op_stall,
  output logic            op_wr_en,
  output logic [4:0]      op_rd_addr,
  output logic [XLEN-1:0] op_wr_data,
  output logic [31:0]     op_busy_vec
);

  logic            mdu_go;
  logic            alu_go;
  logic            starve;
  logic            wr_en_q;
  logic            wr_mdu_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] wr_data_q;
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;

`ifdef RWA_STARVE_EN
  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] wait_q;
  logic [CntW-1:0] wait_d;

  assign starve = (wait_q == CntW'(MAX_WAIT));

  // Count consecutive denied ALU cycles, saturating at MAX_WAIT
  always_comb begin
    wait_d = wait_q;
    if (!ip_alu_valid || alu_go) begin
      wait_d = '0;
    end else if (!starve) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Wait counter register
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_max_wait;

  assign starve          = 1'b0;
  assign unused_max_wait = ^MAX_WAIT;
`endif

  // Grant decode: MDU wins unless the ALU has waited too long; nothing while in reset
  always_comb begin
    op_mdu_ready = 1'b0;
    op_alu_ready = 1'b0;
    if (!ip_rst) begin
      op_mdu_ready = ~starve;
      op_alu_ready = starve | ~ip_mdu_valid;
    end
  end

  assign mdu_go = ip_mdu_valid & op_mdu_ready;
  assign alu_go = ip_alu_valid & op_alu_ready;

  // Register the granted write; rd=0 completes the handshake without a write pulse
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      wr_en_q   <= 1'b0;
      wr_mdu_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_data_q <= '0;
    end else if (mdu_go) begin
      wr_en_q   <= (ip_mdu_rd_addr != 5'd0);
      wr_mdu_q  <= 1'b1;
      rd_addr_q <= ip_mdu_rd_addr;
      wr_data_q <= ip_mdu_data;
    end else if (alu_go) begin
      wr_en_q   <= (ip_alu_rd_addr != 5'd0);
      wr_mdu_q  <= 1'b0;
      rd_addr_q <= ip_alu_rd_addr;
      wr_data_q <= ip_alu_data;
    end else begin
      wr_en_q  <= 1'b0;
      wr_mdu_q <= 1'b0;
    end
  end

  // Scoreboard next state: clear on MDU commit, then set on issue so set wins
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q && wr_mdu_q) begin
      busy_d[rd_addr_q] = 1'b0;
    end
    if (ip_mdu_issue && (ip_mdu_issue_rd != 5'd0)) begin
      busy_d[ip_mdu_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // x0 is never busy, so index 0 can never raise the stall
  assign op_stall    = busy_q[ip_rs1_addr] | busy_q[ip_rs2_addr] | busy_q[ip_dec_rd_addr];
  assign op_wr_en    = wr_en_q;
  assign op_rd_addr  = rd_addr_q;
  assign op_wr_data  = wr_data_q;
  assign op_busy_vec = busy_q;

endmodule
